// File: rtl/bit_scan_32.sv
// rtl/bit_scan_32.sv - multi-cycle 32-bit bit-scan: any-set flag, lowest/highest set index, popcount
// Examines STEP bits per clock, LSB chunk first, over a fixed 32/STEP cycles.

module bit_scan_32 #(
    parameter int STEP = 8
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        START,
    input  logic        MODE,
    input  logic [31:0] IN,
    output logic        BUSY,
    output logic        DONE,
    output logic        FOUND,
    output logic [4:0]  INDEX,
    output logic [5:0]  COUNT
);

    typedef enum logic {
        S_IDLE,
        S_SCAN
    } state_t;

    // r_base holds k*STEP of the chunk now at the bottom of r_operand; it doubles as the chunk counter.
    localparam logic [4:0] BASE_INC  = 5'(STEP);
    localparam logic [4:0] LAST_BASE = 5'(32 - STEP);

    state_t      r_state;
    logic [31:0] r_operand;
    logic        r_mode;
    logic [4:0]  r_base;
    logic        r_acc_found;
    logic [4:0]  r_acc_index;
    logic [5:0]  r_acc_count;

    logic [STEP-1:0] w_chunk;
    logic            w_any;
    logic [5:0]      w_pop;
    logic [4:0]      w_lo;
    logic [4:0]      w_hi;
    logic            w_found_nxt;
    logic [4:0]      w_index_nxt;
    logic [5:0]      w_count_nxt;

    assign w_chunk = r_operand[STEP-1:0];

    always_comb begin
        w_any = |w_chunk;
        w_pop = 6'd0;
        w_lo  = 5'd0;
        w_hi  = 5'd0;
        for (int i = STEP - 1; i >= 0; i--) begin
            if (w_chunk[i]) w_lo = 5'(i);
        end
        for (int i = 0; i < STEP; i++) begin
            if (w_chunk[i]) w_hi = 5'(i);
            w_pop = w_pop + 6'(w_chunk[i]);
        end
    end

    // Lowest mode keeps the first hit; highest mode lets every later hit overwrite.
    always_comb begin
        w_found_nxt = r_acc_found | w_any;
        w_count_nxt = r_acc_count + w_pop;
        w_index_nxt = r_acc_index;
        if (w_any) begin
            if (r_mode) begin
                w_index_nxt = r_base + w_hi;
            end else if (!r_acc_found) begin
                w_index_nxt = r_base + w_lo;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state     <= S_IDLE;
            r_operand   <= 32'd0;
            r_mode      <= 1'b0;
            r_base      <= 5'd0;
            r_acc_found <= 1'b0;
            r_acc_index <= 5'd0;
            r_acc_count <= 6'd0;
            BUSY        <= 1'b0;
            DONE        <= 1'b0;
            FOUND       <= 1'b0;
            INDEX       <= 5'd0;
            COUNT       <= 6'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    DONE <= 1'b0;
                    if (START) begin
                        r_operand   <= IN;
                        r_mode      <= MODE;
                        r_base      <= 5'd0;
                        r_acc_found <= 1'b0;
                        r_acc_index <= 5'd0;
                        r_acc_count <= 6'd0;
                        BUSY        <= 1'b1;
                        r_state     <= S_SCAN;
                    end
                end
                S_SCAN: begin
                    r_acc_found <= w_found_nxt;
                    r_acc_index <= w_index_nxt;
                    r_acc_count <= w_count_nxt;
                    r_operand   <= r_operand >> STEP;
                    r_base      <= r_base + BASE_INC;
                    if (r_base == LAST_BASE) begin
                        FOUND   <= w_found_nxt;
                        INDEX   <= w_index_nxt;
                        COUNT   <= w_count_nxt;
                        BUSY    <= 1'b0;
                        DONE    <= 1'b1;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/bit_scan_32.md
Name: bit_scan_32

Overview:
- Multi-cycle bit-scan unit for 32-bit words.
- Given a 32-bit operand, it reports whether any bit is set, the index of the lowest or highest set bit, and the population count.
- Sits beside the ALU in the RISC-V datapath. It serves bit-manipulation and count-leading/trailing-zero style operations, and acts as a reusable "which bit" locator complementing the combinational any-bit-set zero-flag logic.
- Start/done handshake; processes STEP bits per clock.

Parameters:
- STEP, 8, bits examined per clock. Legal values are 1, 2, 4, 8, 16, 32. Number of scan cycles C = 32/STEP.

Ports:
- CLK  input  1  system clock; all logic rising-edge.
- RST  input  1  synchronous, active-high reset.
- START  input  1  request; accepted only when BUSY=0.
- MODE  input  1  0 = find lowest set bit, 1 = find highest set bit. Sampled with START.
- IN  input  32  operand. Sampled with START.
- BUSY  output  1  high while a scan is in progress.
- DONE  output  1  one-cycle pulse; results valid from this cycle.
- FOUND  output  1  1 if any bit of captured operand is set.
- INDEX  output  5  located bit index. 0 when FOUND=0.
- COUNT  output  6  number of set bits, 0..32.

Interface decision: one clock; reset is synchronous and active-high (CLK, RST).

Behaviour:
- Reset (RST=1 at a rising edge):
  - state=IDLE; BUSY=0, DONE=0, FOUND=0, INDEX=0, COUNT=0.
  - Internal operand, mode, and chunk counter cleared.
  - RST has priority over START and over any scan in progress.
- FSM states:
  - IDLE: BUSY=0. On START=1 at edge 0:
    - Capture IN and MODE.
    - Chunk counter=0, clear partial FOUND/INDEX/COUNT accumulators.
    - Go to SCAN.
    - Published outputs FOUND/INDEX/COUNT keep their previous values until the new DONE.
  - SCAN: BUSY=1. Each edge processes chunk k = bits [k*STEP+STEP-1 : k*STEP], for k=0..C-1, always LSB chunk first.
    - COUNT accumulator += popcount(chunk).
    - FOUND accumulator |= OR(chunk).
    - MODE=0: first chunk containing a set bit latches INDEX = k*STEP + lowest set position within the chunk. Later chunks do not overwrite it.
    - MODE=1: every chunk containing a set bit overwrites INDEX = k*STEP + highest set position within the chunk.
    - At edge C (last chunk): publish accumulators to FOUND/INDEX/COUNT, DONE=1 for the following cycle only, return to IDLE (BUSY=0).
- Latency:
  - START sampled at edge 0 → DONE visible after edge C.
  - STEP=8: 4 cycles; STEP=32: 1 cycle; STEP=1: 32 cycles.
- Scan length: always the full C cycles. There is no early termination, so latency is data-independent.
- START while BUSY=1: ignored. No queuing; captured operand unaffected.
- START in the cycle DONE=1: accepted (state is IDLE). Back-to-back throughput is one result per C cycles.
- Zero operand: FOUND=0, INDEX=0, COUNT=0, DONE still pulses.
- COUNT width: 6 bits so that 32 is representable; no wrap.
- IN/MODE changes during SCAN: no effect.
- RST during SCAN: abort immediately to reset values; no DONE pulse for the aborted scan.
- DONE is never high while BUSY is high.

Test Plan:
- Reset then IN=0x00000000, MODE=0, START → DONE after 4 cycles (STEP=8), FOUND=0, INDEX=0, COUNT=0.
- IN=0x00010100, MODE=0 → FOUND=1, INDEX=8, COUNT=2. Same IN, MODE=1 → INDEX=16, COUNT=2.
- IN=0xFFFFFFFF: MODE=0 → INDEX=0, COUNT=32. MODE=1 → INDEX=31, COUNT=32. Also IN=0x80000000, MODE=0 → INDEX=31, COUNT=1.
- Start IN=0x00000001, then START with IN=0x80000000 two cycles later (BUSY=1) → second request ignored; result INDEX=0, COUNT=1. START asserted in the DONE cycle with IN=0x00F00000, MODE=1 → accepted; next DONE exactly 4 cycles later, INDEX=23, COUNT=4.
- Start IN=0x0000FF00, assert RST on the 2nd SCAN cycle → BUSY=0, DONE never pulses, all outputs 0. Fresh START afterwards completes normally: MODE=0 → INDEX=8, COUNT=8.
- Rebuild with STEP=1 and STEP=32. IN=0x00000400, MODE=1 → DONE after 32 cycles and after 1 cycle respectively, INDEX=10, COUNT=1.
